// File: rtl/ib_pc_pkg.sv
// Shared definitions for the instruction-fetch PC sequencer.
// Holds the opcode encoding used by both the control unit and the sequencer.
// No logic; the package only provides types and constants.
package ib_pc_pkg;

  localparam int PC_OP_W = 3;

  // The encoding is fixed because the control unit drives these raw codes.
  // Codes 5..7 are reserved and execute as OP_SEQ.
  typedef enum logic [PC_OP_W-1:0] {
    OP_SEQ  = 3'd0,
    OP_BR   = 3'd1,
    OP_JMP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_t;

endpackage : ib_pc_pkg

// File: rtl/ib_ras.sv
// Return-address stack: a circular LIFO that overwrites its oldest entry on overflow.
// Latency: push/pop take effect at the clock edge; top/full/empty reflect it the next cycle.
// Backpressure: none. Overflow and underflow are reported through one-cycle ovf/unf pulses.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   push, push_data  store push_data as the new top (wins over pop if both are high)
//   pop              discard the top entry; flags unf if the stack is empty
//   top              current top entry (valid only when empty=0)
//   full, empty      registered occupancy flags
//   ovf, unf         registered one-cycle event pulses
module ib_ras #(
  parameter int AWIDTH    = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [AWIDTH-1:0] push_data,
  output logic [AWIDTH-1:0] top,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [AWIDTH-1:0] mem_q [RAS_DEPTH];
  logic [AWIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;

    if (push) begin
      // The write pointer always advances; on a full stack the slot it lands
      // on is the oldest entry, so the circular buffer drops it implicitly.
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + PW'(1);
      if (full_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop) begin
      if (empty_q) begin
        unf_d = 1'b1;
      end else begin
        wptr_d = wptr_q - PW'(1);
        cnt_d  = cnt_q - CW'(1);
      end
    end

    full_d  = (cnt_d == CW'(RAS_DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Most recent entry sits just below the write pointer.
  assign top   = mem_q[wptr_q - PW'(1)];
  assign full  = full_q;
  assign empty = empty_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule : ib_ras

// File: rtl/ib_pc_sequencer.sv
// Registered program counter with sequential step, relative branch, jump, call and return.
// Latency: 1 cycle from the op sampled at a rising edge to the new value on pc.
// Backpressure: en=0 stalls; pc and the return-address stack hold and no flags pulse.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   en                    advance enable
//   op, br_taken          operation code and branch condition
//   target, offset        absolute destination and signed branch displacement
//   pc                    registered current PC
//   ras_full, ras_empty   return-address stack occupancy
//   ras_ovf, ras_unf      one-cycle overflow/underflow pulses
module ib_pc_sequencer
  import ib_pc_pkg::*;
#(
  parameter int AWIDTH    = 6,
  parameter int STEP      = 1,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PC_OP_W-1:0] op,
  input  logic               br_taken,
  input  logic [AWIDTH-1:0]  target,
  input  logic [AWIDTH-1:0]  offset,
  output logic [AWIDTH-1:0]  pc,
  output logic               ras_full,
  output logic               ras_empty,
  output logic               ras_ovf,
  output logic               ras_unf
);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] seq;
  logic [AWIDTH-1:0] ras_top;
  logic              ras_push;
  logic              ras_pop;
  pc_op_t            op_e;

  assign op_e     = pc_op_t'(op);
  assign seq      = pc_q + AWIDTH'(STEP);
  assign ras_push = en && (op_e == OP_CALL);
  assign ras_pop  = en && (op_e == OP_RET);

  ib_ras #(
    .AWIDTH    (AWIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      case (op_e)
        // Offset is two's complement at AWIDTH, so an unsigned add at the
        // same width gives the signed result modulo 2^AWIDTH.
        OP_BR:   pc_d = br_taken ? (pc_q + offset) : seq;
        OP_JMP:  pc_d = target;
        OP_CALL: pc_d = target;
        OP_RET:  pc_d = ras_empty ? seq : ras_top;
        default: pc_d = seq;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= AWIDTH'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : ib_pc_sequencer
